// File: rtl/tdm_mux8to1.sv
// Time-division 8-to-1 serializer: scans the masked channels of a per-frame
// snapshot in ascending order, holding each slot for HOLD_CYCLES clocks.
module tdm_mux8to1 #(
    parameter int unsigned HOLD_CYCLES = 1,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] dins,
    input  logic [7:0] ch_mask,
    output logic       dout,
    output logic [2:0] sel_out,
    output logic       valid_out,
    output logic       frame_start
);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t           state, state_n;
    logic [7:0]       snap_d, snap_d_n;
    logic [7:0]       snap_m, snap_m_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             dout_n, valid_n, fs_n;
    logic [2:0]       sel_n;
    logic             start, load;
    logic [3:0]       first, nxt;

    // {found, index} of the lowest set bit of m
    function automatic logic [3:0] first_set(input logic [7:0] m);
        logic [3:0] r;
        logic [2:0] j;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            j = 3'(7 - i);
            if (m[j]) r = {1'b1, j};
        end
        return r;
    endfunction

    // {found, index} of the lowest set bit of m strictly above cur
    function automatic logic [3:0] next_set(input logic [7:0] m, input logic [2:0] cur);
        logic [3:0] r;
        logic [2:0] j;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            j = 3'(7 - i);
            if (m[j] && (j > cur)) r = {1'b1, j};
        end
        return r;
    endfunction

    always_comb begin
        state_n  = state;
        snap_d_n = snap_d;
        snap_m_n = snap_m;
        cnt_n    = cnt;
        dout_n   = dout;
        sel_n    = sel_out;
        valid_n  = valid_out;
        fs_n     = 1'b0;
        load     = 1'b0;
        start    = enable && (ch_mask != '0);
        first    = first_set(ch_mask);
        nxt      = next_set(snap_m, sel_out);

        unique case (state)
            IDLE: begin
                valid_n = 1'b0;
                dout_n  = 1'b0;
                load    = start;
            end
            SCAN: begin
                if (!enable) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                    dout_n  = 1'b0;
                end else if (cnt != CNT_W'(HOLD_CYCLES)) begin
                    cnt_n = cnt + CNT_W'(1);
                end else if (nxt[3]) begin
                    sel_n  = nxt[2:0];
                    dout_n = snap_d[nxt[2:0]];
                    cnt_n  = CNT_W'(1);
                end else if (start) begin
                    load = 1'b1;
                end else begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                    dout_n  = 1'b0;
                end
            end
        endcase

        // Frame start is shared by the IDLE entry and the back-to-back case
        if (load) begin
            state_n  = SCAN;
            snap_d_n = dins;
            snap_m_n = ch_mask;
            sel_n    = first[2:0];
            dout_n   = dins[first[2:0]];
            valid_n  = 1'b1;
            fs_n     = 1'b1;
            cnt_n    = CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            snap_d      <= '0;
            snap_m      <= '0;
            cnt         <= '0;
            dout        <= 1'b0;
            sel_out     <= '0;
            valid_out   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            snap_d      <= snap_d_n;
            snap_m      <= snap_m_n;
            cnt         <= cnt_n;
            dout        <= dout_n;
            sel_out     <= sel_n;
            valid_out   <= valid_n;
            frame_start <= fs_n;
        end
    end

endmodule

// File: tb/tb_tdm_mux8to1.sv
// Bench for tdm_mux8to1: HOLD_CYCLES=1 and HOLD_CYCLES=3 instances share stimulus
// and are checked every cycle against a frame/position model.
module tb_tdm_mux8to1;

    logic       clk = 1'b0;
    logic       rst, enable;
    logic [7:0] dins, ch_mask;

    logic       d_dout  [2];
    logic [2:0] d_sel   [2];
    logic       d_valid [2];
    logic       d_fs    [2];

    int n_cmp = 0;
    int n_err = 0;
    bit go = 1'b0;

    always #5 clk = ~clk;

    tdm_mux8to1 #(.HOLD_CYCLES(1), .CNT_W(8)) u_h1 (
        .clk(clk), .rst(rst), .enable(enable), .dins(dins), .ch_mask(ch_mask),
        .dout(d_dout[0]), .sel_out(d_sel[0]), .valid_out(d_valid[0]), .frame_start(d_fs[0])
    );

    tdm_mux8to1 #(.HOLD_CYCLES(3), .CNT_W(8)) u_h3 (
        .clk(clk), .rst(rst), .enable(enable), .dins(dins), .ch_mask(ch_mask),
        .dout(d_dout[1]), .sel_out(d_sel[1]), .valid_out(d_valid[1]), .frame_start(d_fs[1])
    );

    task automatic chk(input string name, input int k, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s inst%0d: got %0d expected %0d at %0t", name, k, act, exp, $time);
        end
    endtask

    // Model: a frame is the list of masked channels, each repeated hold times;
    // pos walks through it and the slot's channel is the (pos/hold)-th set bit.
    int unsigned hold [2] = '{1, 3};
    bit          m_act  [2] = '{0, 0};
    int unsigned m_pos  [2] = '{0, 0};
    int unsigned m_len  [2] = '{0, 0};
    logic [7:0]  m_fd   [2];
    logic [7:0]  m_fm   [2];
    logic        e_dout [2] = '{0, 0};
    logic [2:0]  e_sel  [2] = '{0, 0};
    logic        e_valid[2] = '{0, 0};
    logic        e_fs   [2] = '{0, 0};

    function automatic int nth_set(input logic [7:0] m, input int unsigned n);
        int unsigned seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                if (seen == n) return i;
                seen++;
            end
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit          a;
            int unsigned p, len;
            logic [7:0]  fd, fm;
            int          ch;
            a = m_act[k]; p = m_pos[k]; len = m_len[k]; fd = m_fd[k]; fm = m_fm[k];
            if (rst) begin
                m_act[k] <= 1'b0;
                e_dout[k] <= 1'b0; e_sel[k] <= 3'd0; e_valid[k] <= 1'b0; e_fs[k] <= 1'b0;
            end else begin
                if (a && enable && (p + 1 < len)) begin
                    p = p + 1;
                end else if (enable && ch_mask != 8'h00) begin
                    a = 1'b1; p = 0; fd = dins; fm = ch_mask;
                    len = $countones(ch_mask) * hold[k];
                end else begin
                    a = 1'b0;
                end
                m_act[k] <= a; m_pos[k] <= p; m_len[k] <= len; m_fd[k] <= fd; m_fm[k] <= fm;
                if (a) begin
                    ch = nth_set(fm, p / hold[k]);
                    e_sel[k]   <= 3'(ch);
                    e_dout[k]  <= fd[ch];
                    e_valid[k] <= 1'b1;
                    e_fs[k]    <= (p == 0);
                end else begin
                    e_dout[k]  <= 1'b0;
                    e_valid[k] <= 1'b0;
                    e_fs[k]    <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (go) begin
            for (int k = 0; k < 2; k++) begin
                chk("model_valid", k, int'(d_valid[k]), int'(e_valid[k]));
                chk("model_sel",   k, int'(d_sel[k]),   int'(e_sel[k]));
                chk("model_dout",  k, int'(d_dout[k]),  int'(e_dout[k]));
                chk("model_fs",    k, int'(d_fs[k]),    int'(e_fs[k]));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_gap();
        enable = 1'b0;
        cyc(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        int sel2 [6] = '{0, 2, 7, 0, 2, 7};
        int sel3 [7] = '{0, 0, 0, 1, 1, 1, 0};
        int fs3  [7] = '{1, 0, 0, 0, 0, 0, 1};

        rst = 1'b1; enable = 1'b0; dins = 8'h00; ch_mask = 8'h00;
        cyc(2);
        chk("reset_valid", 0, int'(d_valid[0]), 0);
        chk("reset_sel",   0, int'(d_sel[0]),   0);
        chk("reset_dout",  1, int'(d_dout[1]),  0);
        chk("reset_fs",    1, int'(d_fs[1]),    0);
        go = 1'b1;
        rst = 1'b0;
        cyc(1);

        // Full mask, HOLD=1: sel 0..7, dout follows dins, then wrap with frame_start
        v = 8'b1010_0101;
        dins = v; ch_mask = 8'hFF; enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            chk("t1_sel",  0, int'(d_sel[0]),  i);
            chk("t1_dout", 0, int'(d_dout[0]), int'(v[i]));
            chk("t1_fs",   0, int'(d_fs[0]),   (i == 0) ? 1 : 0);
        end
        cyc(1);
        chk("t1_wrap_sel", 0, int'(d_sel[0]), 0);
        chk("t1_wrap_fs",  0, int'(d_fs[0]),  1);

        // Sparse mask 1000_0101
        idle_gap();
        dins = 8'hFF; ch_mask = 8'b1000_0101; enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            chk("t2_sel",   0, int'(d_sel[0]),   sel2[i]);
            chk("t2_valid", 0, int'(d_valid[0]), 1);
            chk("t2_fs",    0, int'(d_fs[0]),    (i % 3 == 0) ? 1 : 0);
        end

        // HOLD=3, mask 03, dins 02
        idle_gap();
        dins = 8'b10; ch_mask = 8'h03; enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc(1);
            chk("t3_sel",  1, int'(d_sel[1]),  sel3[i]);
            chk("t3_dout", 1, int'(d_dout[1]), sel3[i]);
            chk("t3_fs",   1, int'(d_fs[1]),   fs3[i]);
        end

        // dins change mid-frame is invisible until the next snapshot
        idle_gap();
        dins = 8'h00; ch_mask = 8'hFF; enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc(1);
            if (i == 2) dins = 8'hFF;
            chk("t4_dout", 0, int'(d_dout[0]), (i < 8) ? 0 : 1);
        end

        // enable dropped at slot 4, then re-enabled
        idle_gap();
        dins = 8'hA5; ch_mask = 8'hFF; enable = 1'b1;
        cyc(5);
        chk("t5_sel4", 0, int'(d_sel[0]), 4);
        enable = 1'b0;
        cyc(1);
        chk("t5_valid_drop", 0, int'(d_valid[0]), 0);
        chk("t5_sel_hold",   0, int'(d_sel[0]),   4);
        enable = 1'b1;
        cyc(1);
        chk("t5_restart_sel", 0, int'(d_sel[0]), 0);
        chk("t5_restart_fs",  0, int'(d_fs[0]),  1);

        // Reset mid-frame, then enable with an empty mask
        cyc(2);
        rst = 1'b1;
        cyc(1);
        chk("t6_rst_valid", 0, int'(d_valid[0]), 0);
        chk("t6_rst_sel",   0, int'(d_sel[0]),   0);
        chk("t6_rst_valid", 1, int'(d_valid[1]), 0);
        cyc(1);
        rst = 1'b0; ch_mask = 8'h00; enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("t6_nomask_valid", 0, int'(d_valid[0]), 0);
            chk("t6_nomask_valid", 1, int'(d_valid[1]), 0);
        end

        // Single-channel mask: one slot per frame
        ch_mask = 8'b0001_0000; dins = 8'h10;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("t7_sel", 0, int'(d_sel[0]), 4);
            chk("t7_fs",  0, int'(d_fs[0]),  1);
        end

        // Mixed sequence checked only by the model
        for (int i = 0; i < 48; i++) begin
            case (i / 8)
                0: ch_mask = 8'h81;
                1: ch_mask = 8'h3C;
                2: ch_mask = 8'h00;
                3: ch_mask = 8'h80;
                4: ch_mask = 8'hFF;
                default: ch_mask = 8'h5A;
            endcase
            dins = 8'(i * 37 + 11);
            enable = (i % 13 != 12);
            cyc(1);
        end

        enable = 1'b0;
        cyc(2);
        go = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tdm_mux8to1.md
Name: tdm_mux8to1

Overview:
Time-division 8-to-1 multiplexer/serializer. It is the transmit end of the 1-to-8 demultiplexed link.
- Scans eight parallel input bits in round-robin order and emits one bit per slot on `dout`.
- Drives `sel_out` with the channel index, so a downstream demux1to8 driven with the same `sel` routes each bit back to its channel.
- Frames are coherent: inputs and channel mask are snapshotted at each frame start.

Parameters:
HOLD_CYCLES, 1, clock cycles each channel slot is held on the output (legal range 1..255).
CNT_W, 8, width of the slot-hold counter; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  synchronous active-high reset
enable  input  1  run request; low forces the block back to IDLE
dins  input  8  parallel channel data, bit i = channel i
ch_mask  input  8  channel enable mask; bit i=1 means channel i is transmitted
dout  output  1  serialized data bit for the current slot
sel_out  output  3  channel index of the current slot (drives demux sel)
valid_out  output  1  high while dout/sel_out carry a valid slot
frame_start  output  1  one-cycle pulse on the first cycle of the first slot of each frame

Behaviour:
- All outputs are registered; no combinational path from inputs to outputs.
- Reset (rst=1 at a clk edge), which overrides everything:
  - state=IDLE.
  - dout=0, sel_out=3'b000, valid_out=0, frame_start=0.
  - Snapshots and hold counter cleared.
  - Reset asserted mid-frame aborts the frame immediately; nothing is completed.
- States: IDLE, SCAN.
- IDLE:
  - valid_out=0, frame_start=0, dout=0, sel_out holds its last value.
  - At an edge with enable=1 and ch_mask!=0, start a frame:
    - snap_d<=dins, snap_m<=ch_mask.
    - sel_out<=lowest set bit index of ch_mask.
    - dout<=dins[that index], valid_out<=1, frame_start<=1.
    - hold counter<=1; go to SCAN.
    - Latency is one cycle: outputs appear on the edge that samples enable.
  - With enable=1 and ch_mask==0: remain in IDLE, valid_out=0.
- SCAN:
  - frame_start=0 after its first cycle.
  - Each slot lasts exactly HOLD_CYCLES cycles; dout and sel_out are stable for the whole slot.
  - When the hold counter reaches HOLD_CYCLES, advance to the next set bit of snap_m above the current sel_out. dout<=snap_d[next], counter<=1.
  - Masked-off channels are skipped with zero cycles consumed.
- End of frame (no set bit in snap_m above the current index, at the last hold cycle):
  - If enable=1 and ch_mask!=0: start the next frame back-to-back on the next edge with no idle gap. New snapshot taken, frame_start pulses again.
  - Otherwise go to IDLE; valid_out=0 on that edge.
- enable deasserted during SCAN: at the next edge go to IDLE, valid_out=0, and the partial frame is dropped. enable is not sampled again until that edge completes.
- dins/ch_mask changes during SCAN have no effect until the next frame snapshot.
- Single-channel mask (e.g. 8'b0001_0000): every frame is one slot. sel_out stays at 4 and frame_start pulses every HOLD_CYCLES cycles.
- Full mask: frame length is 8*HOLD_CYCLES cycles. sel_out wraps 7 -> 0 at the frame boundary.
- X/Z on enable or ch_mask is not a supported input; no recovery behaviour is defined for it.

Test Plan:
1. Reset, then HOLD_CYCLES=1, enable=1, ch_mask=8'hFF, dins=8'b1010_0101 -> frame_start on cycle 1. sel_out steps 0..7 over 8 cycles; dout = 1,0,1,0,0,1,0,1; then sel_out wraps to 0 with frame_start again.
2. ch_mask=8'b1000_0101, dins=8'hFF -> sel_out sequence 0,2,7,0,2,7…; valid_out constantly 1; frame_start every 3 cycles.
3. HOLD_CYCLES=3, ch_mask=8'h03, dins=8'b10 -> sel_out=0/dout=0 for 3 cycles, then sel_out=1/dout=1 for 3 cycles, then repeat.
4. Change dins from 8'h00 to 8'hFF mid-frame (mask 8'hFF) -> dout stays 0 for the rest of the frame; the next frame outputs all 1s.
5. Deassert enable at slot 4 -> valid_out=0 on the next edge. Re-enable -> new frame starts at sel_out=0 with frame_start=1.
6. Assert rst mid-frame, or run with ch_mask=8'h00 -> all outputs return to or stay at reset values; valid_out=0 for the entire interval.
